// File: rtl/hex_display_sampler_pkg.sv
// rtl/hex_display_sampler_pkg.sv - shared constants and types for the hex display sampler
package hex_display_sampler_pkg;

  localparam int DEF_TICK_DIV    = 50000;
  localparam int DEF_DWELL_MS    = 2000;
  localparam int DEF_REFRESH_MS  = 250;
  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int NUM_PAGES       = 4;
  localparam int PAGE_W          = 32;

  typedef logic [1:0]        page_idx_t;
  typedef logic [PAGE_W-1:0] page_word_t;

  // Counter width for a 0..limit-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/hex_display_sampler_key_debounce.sv
// rtl/hex_display_sampler_key_debounce.sv - key synchronizer, tick-based debounce and press event
module key_debounce
  import hex_display_sampler_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_n,
  output logic press
);

  localparam int            W    = cnt_w(DEBOUNCE_MS);
  localparam logic [W-1:0]  LAST = W'(DEBOUNCE_MS - 1);

  logic         sync1;
  logic         sync2;
  logic         state;
  logic [W-1:0] cnt;

  // Any return to the debounced level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == LAST) begin
          state <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign press = tick && state && !sync2 && (cnt == LAST);

endmodule

// File: rtl/hex_display_sampler.sv
// rtl/hex_display_sampler.sv - rotating, periodically resampled page feeder for the hex indicator
module hex_display_sampler
  import hex_display_sampler_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int DWELL_MS    = DEF_DWELL_MS,
  parameter int REFRESH_MS  = DEF_REFRESH_MS,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PAGES*PAGE_W-1:0]   page_data,
  input  logic [NUM_PAGES-1:0]          page_valid,
  input  logic                          key_next_n,
  input  logic                          key_hold_n,
  output logic [PAGE_W-1:0]             disp_value,
  output page_idx_t                     page_idx,
  output logic                          hold_active,
  output logic                          sample_strobe
);

  localparam int TW = cnt_w(TICK_DIV);
  localparam int DW = cnt_w(DWELL_MS);
  localparam int RW = cnt_w(REFRESH_MS);
  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_MS - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_MS - 1);

  logic [TW-1:0] pre_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [RW-1:0] refresh_cnt;
  logic          started;
  logic          tick;
  logic          next_press;
  logic          hold_press;
  logic          adv;
  logic          refresh;
  page_idx_t     search_start;
  logic [2:0]    found;
  page_word_t    pages [NUM_PAGES];

  // Returns {found, index} of the first valid page at or after start, circularly.
  function automatic logic [2:0] find_next(input logic [NUM_PAGES-1:0] valid,
                                           input page_idx_t start);
    logic [2:0] r;
    page_idx_t  k;
    r = '0;
    for (int i = NUM_PAGES - 1; i >= 0; i--) begin
      k = start + page_idx_t'(i);
      if (valid[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_PAGES; k++) pages[k] = page_data[k*PAGE_W +: PAGE_W];
  end

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_next (
    .clk(clk), .rst(rst), .tick(tick), .key_n(key_next_n), .press(next_press)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_hold (
    .clk(clk), .rst(rst), .tick(tick), .key_n(key_hold_n), .press(hold_press)
  );

  // Before the first sample the search includes page 0 itself.
  assign tick         = (pre_cnt == TICK_LAST);
  assign search_start = started ? page_idx + 2'd1 : 2'd0;
  assign found        = find_next(page_valid, search_start);
  assign adv          = next_press || (tick && !started) ||
                        (tick && !hold_active && (dwell_cnt == DWELL_LAST));
  assign refresh      = tick && !hold_active && !adv && (refresh_cnt == REFRESH_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt       <= '0;
      dwell_cnt     <= '0;
      refresh_cnt   <= '0;
      started       <= 1'b0;
      disp_value    <= '0;
      page_idx      <= '0;
      hold_active   <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      pre_cnt       <= tick ? '0 : pre_cnt + 1'b1;
      sample_strobe <= adv || refresh;
      if (hold_press) hold_active <= !hold_active;
      if (adv) begin
        started     <= 1'b1;
        dwell_cnt   <= '0;
        refresh_cnt <= '0;
        if (found[2]) begin
          page_idx   <= found[1:0];
          disp_value <= pages[found[1:0]];
        end else begin
          disp_value <= '0;
        end
      end else if (refresh) begin
        refresh_cnt <= '0;
        dwell_cnt   <= dwell_cnt + 1'b1;
        disp_value  <= page_valid[page_idx] ? pages[page_idx] : '0;
      end else if (tick && !hold_active) begin
        dwell_cnt   <= dwell_cnt + 1'b1;
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

endmodule
